// File: rtl/cpu_int_dispatch_pkg.sv
// -----------------------------------------------------------------------------
// int_pkg
// Shared definitions for the CPU interrupt dispatch block:
//   - NIRQ / VEC_BASE defaults (five sources, vectors at 0x40 + 8*n)
//   - source index constants
//   - dispatch sequencer state encoding
// -----------------------------------------------------------------------------
package int_pkg;

  localparam int          NIRQ     = 5;
  localparam logic [15:0] VEC_BASE = 16'h0040;

  localparam int INT_VBL    = 0;
  localparam int INT_STAT   = 1;
  localparam int INT_TIMER  = 2;
  localparam int INT_SERIAL = 3;
  localparam int INT_JOYP   = 4;

  // IDLE, then five dispatch M-cycles: two wait cycles, PC high push,
  // PC low push, jump to vector.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_W1      = 3'd1,
    ST_W2      = 3'd2,
    ST_PUSH_HI = 3'd3,
    ST_PUSH_LO = 3'd4,
    ST_JUMP    = 3'd5
  } state_t;

endpackage

// File: rtl/cpu_int_dispatch_int_prio_enc.sv
// -----------------------------------------------------------------------------
// int_prio_enc
// Combinational lowest-set-bit priority encoder for the interrupt sources.
// Ports:
//   i_req    [NIRQ-1:0]  request mask (already qualified by IE)
//   o_valid              any request bit set
//   o_onehot [NIRQ-1:0]  one-hot of the winning (lowest) bit, 0 if none
//   o_vector [15:0]      VEC_BASE + 8*winner, 0 if none
// -----------------------------------------------------------------------------
module int_prio_enc #(
  parameter int          NIRQ     = int_pkg::NIRQ,
  parameter logic [15:0] VEC_BASE = int_pkg::VEC_BASE
) (
  input  logic [NIRQ-1:0] i_req,
  output logic            o_valid,
  output logic [NIRQ-1:0] o_onehot,
  output logic [15:0]     o_vector
);

  // Scan from the top down so the lowest set bit is the last to write.
  always_comb begin
    o_valid  = 1'b0;
    o_onehot = '0;
    o_vector = 16'h0000;
    for (int n = NIRQ - 1; n >= 0; n--) begin
      if (i_req[n]) begin
        o_valid     = 1'b1;
        o_onehot    = '0;
        o_onehot[n] = 1'b1;
        o_vector    = VEC_BASE + 16'(n * 8);
      end
    end
  end

endmodule

// File: rtl/cpu_int_dispatch.sv
// -----------------------------------------------------------------------------
// cpu_int_dispatch
// CPU-side interrupt endpoint: owns IE (FFFF) and IME, and runs the
// 5 M-cycle dispatch sequence (wait, wait, push PCH, push PCL, jump).
// Ports:
//   clk, reset            M-cycle clock, async active-high reset
//   d[7:0]                CPU data bus; driven with IE while nffff_rd is low
//   nffff_wr / nffff_rd   active-low IE write (clocked) / read (tristate)
//   irq_trig[NIRQ-1:0]    IF flags; irq_ack[NIRQ-1:0] one-hot IF clear
//   instr_boundary        core is in its opcode-fetch M-cycle
//   ei, di, reti          decoder pulses
//   dispatch, push_pch, push_pcl, load_pc, vector[15:0]  sequencer outputs
//   wake                  any enabled request (ignores IME)
//   ime                   current master enable
//   dbg_state             sequencer state for observability
// Handshake: irq_trig is a level; irq_ack is a single-cycle pulse during the
// PUSH_LO cycle, and the IF block is expected to clear that bit on it.
// -----------------------------------------------------------------------------
module cpu_int_dispatch
  import int_pkg::*;
#(
  parameter int          NIRQ     = int_pkg::NIRQ,
  parameter logic [15:0] VEC_BASE = int_pkg::VEC_BASE
) (
  input  logic            clk,
  input  logic            reset,
  inout  wire  [7:0]      d,
  input  logic            nffff_wr,
  input  logic            nffff_rd,
  input  logic [NIRQ-1:0] irq_trig,
  output logic [NIRQ-1:0] irq_ack,
  input  logic            instr_boundary,
  input  logic            ei,
  input  logic            di,
  input  logic            reti,
  output logic            dispatch,
  output logic            push_pch,
  output logic            push_pcl,
  output logic            load_pc,
  output logic [15:0]     vector,
  output logic            wake,
  output logic            ime,
  output state_t          dbg_state
);

  logic [7:0]      r_ie;
  logic            r_ime;
  logic            r_ime_pend;
  state_t          r_state;
  logic [NIRQ-1:0] r_irq_ack;
  logic [15:0]     r_vector;
  logic            r_dispatch;
  logic            r_push_pch;
  logic            r_push_pcl;
  logic            r_load_pc;

  logic [7:0]      w_ie_next;
  logic [NIRQ-1:0] w_pending;
  logic [NIRQ-1:0] w_sel_mask;
  logic            w_take;
  logic            w_ime_next;
  logic            w_pend_next;
  logic            w_sel_valid;
  logic [NIRQ-1:0] w_sel_onehot;
  logic [15:0]     w_sel_vector;

  // IE as it will be after this edge; selection must see a write that lands
  // on FFFF in the same cycle (the PCH push can target FFFF).
  assign w_ie_next  = (!nffff_wr) ? d : r_ie;
  assign w_pending  = irq_trig & r_ie[NIRQ-1:0];
  assign w_sel_mask = irq_trig & w_ie_next[NIRQ-1:0];
  assign w_take     = (r_state == ST_IDLE) && instr_boundary && r_ime && (|w_pending);

  assign d = (!nffff_rd) ? r_ie : 8'hzz;

  int_prio_enc #(
    .NIRQ     (NIRQ),
    .VEC_BASE (VEC_BASE)
  ) u_prio_enc (
    .i_req    (w_sel_mask),
    .o_valid  (w_sel_valid),
    .o_onehot (w_sel_onehot),
    .o_vector (w_sel_vector)
  );

  // IME update; later statements win. Taking an interrupt clears IME, and DI
  // overrides everything including EI and RETI in the same cycle. The EI
  // promotion uses the old IME for this edge's dispatch decision, so one
  // instruction always executes after EI.
  always_comb begin
    w_ime_next  = r_ime;
    w_pend_next = r_ime_pend;
    if (r_ime_pend && instr_boundary) begin
      w_ime_next  = 1'b1;
      w_pend_next = 1'b0;
    end
    if (ei) begin
      w_pend_next = 1'b1;
    end
    if (reti) begin
      w_ime_next = 1'b1;
    end
    if (w_take) begin
      w_ime_next  = 1'b0;
      w_pend_next = 1'b0;
    end
    if (di) begin
      w_ime_next  = 1'b0;
      w_pend_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ie       <= 8'h00;
      r_ime      <= 1'b0;
      r_ime_pend <= 1'b0;
      r_state    <= ST_IDLE;
      r_irq_ack  <= '0;
      r_vector   <= 16'h0000;
      r_dispatch <= 1'b0;
      r_push_pch <= 1'b0;
      r_push_pcl <= 1'b0;
      r_load_pc  <= 1'b0;
    end else begin
      r_ie       <= w_ie_next;
      r_ime      <= w_ime_next;
      r_ime_pend <= w_pend_next;
      r_irq_ack  <= '0;
      r_push_pch <= 1'b0;
      r_push_pcl <= 1'b0;
      r_load_pc  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_take) begin
            r_state    <= ST_W1;
            r_dispatch <= 1'b1;
          end
        end
        ST_W1: begin
          r_state <= ST_W2;
        end
        ST_W2: begin
          r_state    <= ST_PUSH_HI;
          r_push_pch <= 1'b1;
        end
        ST_PUSH_HI: begin
          // Late selection: an empty mask yields vector 0 and no ack.
          r_state    <= ST_PUSH_LO;
          r_push_pcl <= 1'b1;
          r_irq_ack  <= w_sel_onehot;
          r_vector   <= w_sel_valid ? w_sel_vector : 16'h0000;
        end
        ST_PUSH_LO: begin
          r_state   <= ST_JUMP;
          r_load_pc <= 1'b1;
        end
        ST_JUMP: begin
          r_state    <= ST_IDLE;
          r_dispatch <= 1'b0;
          r_vector   <= 16'h0000;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_dispatch <= 1'b0;
          r_vector   <= 16'h0000;
        end
      endcase
    end
  end

  assign irq_ack   = r_irq_ack;
  assign vector    = r_vector;
  assign dispatch  = r_dispatch;
  assign push_pch  = r_push_pch;
  assign push_pcl  = r_push_pcl;
  assign load_pc   = r_load_pc;
  assign wake      = |w_pending;
  assign ime       = r_ime;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_cpu_int_dispatch.sv
// -----------------------------------------------------------------------------
// tb_cpu_int_dispatch
// Directed scenarios plus a randomized run, all compared against a
// behavioural model of the interrupt controller kept in this file.
// -----------------------------------------------------------------------------
module tb_cpu_int_dispatch;
  import int_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUT hookup ----------------
  logic [7:0]  tb_d;
  logic        tb_d_oe;
  wire  [7:0]  d;
  logic        nffff_wr, nffff_rd;
  logic [4:0]  irq_trig;
  logic [4:0]  irq_ack;
  logic        instr_boundary, ei, di, reti;
  logic        dispatch, push_pch, push_pcl, load_pc, wake, ime;
  logic [15:0] vector;
  state_t      dbg_state;

  assign d = tb_d_oe ? tb_d : 8'hzz;

  cpu_int_dispatch dut (
    .clk            (clk),
    .reset          (reset),
    .d              (d),
    .nffff_wr       (nffff_wr),
    .nffff_rd       (nffff_rd),
    .irq_trig       (irq_trig),
    .irq_ack        (irq_ack),
    .instr_boundary (instr_boundary),
    .ei             (ei),
    .di             (di),
    .reti           (reti),
    .dispatch       (dispatch),
    .push_pch       (push_pch),
    .push_pcl       (push_pcl),
    .load_pc        (load_pc),
    .vector         (vector),
    .wake           (wake),
    .ime            (ime),
    .dbg_state      (dbg_state)
  );

  logic [26:0] act_outs;
  assign act_outs = {dispatch, push_pch, push_pcl, load_pc, irq_ack, vector, ime, wake};

  int tests_run;
  int tests_failed;

  // ---------------- reference model ----------------
  // m_cyc: 0 = not dispatching, k = k-th M-cycle of the dispatch sequence.
  logic [7:0]  m_ie;
  logic        m_ime, m_pend;
  int          m_cyc;
  logic [4:0]  m_ack;
  logic [15:0] m_vec;

  function automatic logic [26:0] exp_outs();
    return {(m_cyc != 0), (m_cyc == 3), (m_cyc == 4), (m_cyc == 5),
            m_ack, m_vec, m_ime, (|(irq_trig & m_ie[4:0]))};
  endfunction

  task automatic model_reset();
    m_ie = 8'h00; m_ime = 1'b0; m_pend = 1'b0;
    m_cyc = 0; m_ack = 5'b0; m_vec = 16'h0000;
  endtask

  // Advance the model by one clock edge using the inputs currently applied,
  // clock the DUT, then clear single-cycle pulses and bus writes.
  task automatic tick();
    logic [7:0] ie_nx;
    logic [4:0] mask;
    logic       take, found;
    ie_nx = nffff_wr ? m_ie : tb_d;
    take  = (m_cyc == 0) && instr_boundary && m_ime && ((irq_trig & m_ie[4:0]) != 5'b0);
    m_ack = 5'b0;
    if (m_cyc == 3) begin
      mask  = irq_trig & ie_nx[4:0];
      m_vec = 16'h0000;
      found = 1'b0;
      for (int n = 0; n < 5; n++) begin
        if (mask[n] && !found) begin
          found = 1'b1;
          m_ack = 5'(1 << n);
          m_vec = 16'h0040 + 16'(8 * n);
        end
      end
    end else if (m_cyc == 5) begin
      m_vec = 16'h0000;
    end
    if (m_cyc == 5)      m_cyc = 0;
    else if (m_cyc != 0) m_cyc = m_cyc + 1;
    else if (take)       m_cyc = 1;
    if (m_pend && instr_boundary) begin m_ime = 1'b1; m_pend = 1'b0; end
    if (ei)   m_pend = 1'b1;
    if (reti) m_ime = 1'b1;
    if (take) begin m_ime = 1'b0; m_pend = 1'b0; end
    if (di)   begin m_ime = 1'b0; m_pend = 1'b0; end
    m_ie = ie_nx;
    @(posedge clk);
    #1;
    ei = 1'b0; di = 1'b0; reti = 1'b0;
    nffff_wr = 1'b1; tb_d_oe = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic write_ie(input logic [7:0] val);
    tb_d = val; tb_d_oe = 1'b1; nffff_wr = 1'b0;
    tick();
  endtask

  task automatic boundary_tick();
    instr_boundary = 1'b1;
    tick();
    instr_boundary = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    #2;
    model_reset();
    tests_run++;
    if (act_outs !== 27'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h expected %h", act_outs, 27'd0);
    end
    nffff_rd = 1'b0;
    #1;
    tests_run++;
    if (d !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_ie_read: got %h expected 00", d);
    end
    nffff_rd = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic_dispatch();
    write_ie(8'h1F);
    ei = 1'b1; tick();
    boundary_tick();
    boundary_tick();
    irq_trig = 5'b00100;
    boundary_tick();
    tests_run++;
    if (dispatch !== 1'b1 || dbg_state !== ST_W1) begin
      tests_failed++;
      $display("FAIL basic_enter_w1: got dispatch=%b state=%0d expected 1/%0d", dispatch, dbg_state, ST_W1);
    end
    for (int k = 2; k <= 5; k++) begin
      tick();
      tests_run++;
      if (act_outs !== exp_outs()) begin
        tests_failed++;
        $display("FAIL basic_cycle%0d: got %h expected %h", k, act_outs, exp_outs());
      end
      if (k == 4) begin
        tests_run++;
        if (irq_ack !== 5'b00100 || vector !== 16'h0050) begin
          tests_failed++;
          $display("FAIL basic_ack: got ack=%b vec=%h expected 00100/0050", irq_ack, vector);
        end
        irq_trig = 5'b00000;
      end
    end
    tests_run++;
    if (load_pc !== 1'b1 || vector !== 16'h0050 || ime !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_load_pc: got load=%b vec=%h ime=%b expected 1/0050/0", load_pc, vector, ime);
    end
    tick();
    tests_run++;
    if (act_outs !== exp_outs() || vector !== 16'h0000) begin
      tests_failed++;
      $display("FAIL basic_idle: got %h expected %h", act_outs, exp_outs());
    end
  endtask

  task automatic test_priority();
    logic [4:0]  trig_seq[2];
    logic [15:0] vec_seq[2];
    trig_seq[0] = 5'b10011; vec_seq[0] = 16'h0040;
    trig_seq[1] = 5'b10010; vec_seq[1] = 16'h0048;
    for (int r = 0; r < 2; r++) begin
      irq_trig = trig_seq[r];
      reti = 1'b1; tick();
      boundary_tick();
      for (int k = 2; k <= 6; k++) begin
        tick();
        tests_run++;
        if (act_outs !== exp_outs()) begin
          tests_failed++;
          $display("FAIL prio%0d_cycle%0d: got %h expected %h", r, k, act_outs, exp_outs());
        end
        if (k == 4) begin
          tests_run++;
          if (vector !== vec_seq[r] || irq_ack !== (trig_seq[r] & (~trig_seq[r] + 5'd1))) begin
            tests_failed++;
            $display("FAIL prio%0d_vector: got vec=%h ack=%b expected %h", r, vector, irq_ack, vec_seq[r]);
          end
          irq_trig = irq_trig & ~irq_ack;
        end
      end
    end
    irq_trig = 5'b00000;
  endtask

  task automatic test_late_mask();
    irq_trig = 5'b00001;
    reti = 1'b1; tick();
    boundary_tick();
    tick();
    tick();
    // Now in PUSH_HI: the PCH push clears IE.
    write_ie(8'h00);
    tests_run++;
    if (irq_ack !== 5'b00000 || vector !== 16'h0000 || push_pcl !== 1'b1 || act_outs !== exp_outs()) begin
      tests_failed++;
      $display("FAIL late_mask_sel: got ack=%b vec=%h pcl=%b expected 00000/0000/1", irq_ack, vector, push_pcl);
    end
    tick();
    tests_run++;
    if (load_pc !== 1'b1 || vector !== 16'h0000) begin
      tests_failed++;
      $display("FAIL late_mask_jump: got load=%b vec=%h expected 1/0000", load_pc, vector);
    end
    tick();
    irq_trig = 5'b00000;
    write_ie(8'h1F);
  endtask

  task automatic test_ei_delay();
    irq_trig = 5'b00100;
    ei = 1'b1;
    boundary_tick();
    tests_run++;
    if (dispatch !== 1'b0 || ime !== 1'b0) begin
      tests_failed++;
      $display("FAIL ei_boundary_n: got dispatch=%b ime=%b expected 0/0", dispatch, ime);
    end
    boundary_tick();
    tests_run++;
    if (dispatch !== 1'b0 || ime !== 1'b1) begin
      tests_failed++;
      $display("FAIL ei_boundary_n1: got dispatch=%b ime=%b expected 0/1", dispatch, ime);
    end
    boundary_tick();
    tests_run++;
    if (dispatch !== 1'b1 || ime !== 1'b0) begin
      tests_failed++;
      $display("FAIL ei_boundary_n2: got dispatch=%b ime=%b expected 1/0", dispatch, ime);
    end
    for (int k = 2; k <= 6; k++) begin
      tick();
      if (k == 4) irq_trig = irq_trig & ~irq_ack;
    end
    irq_trig = 5'b00100;
    ei = 1'b1; di = 1'b1; tick();
    boundary_tick();
    boundary_tick();
    tests_run++;
    if (ime !== 1'b0 || dispatch !== 1'b0 || act_outs !== exp_outs()) begin
      tests_failed++;
      $display("FAIL ei_di_same: got ime=%b dispatch=%b expected 0/0", ime, dispatch);
    end
  endtask

  task automatic test_wake();
    write_ie(8'h04);
    irq_trig = 5'b00100;
    tick();
    tests_run++;
    if (wake !== 1'b1 || dispatch !== 1'b0 || ime !== 1'b0) begin
      tests_failed++;
      $display("FAIL wake_no_ime: got wake=%b dispatch=%b expected 1/0", wake, dispatch);
    end
    nffff_rd = 1'b0;
    #1;
    tests_run++;
    if (d !== 8'h04) begin
      tests_failed++;
      $display("FAIL ie_read: got %h expected 04", d);
    end
    nffff_rd = 1'b1;
    irq_trig = 5'b00000;
  endtask

  task automatic test_reset_mid_dispatch();
    write_ie(8'h1F);
    irq_trig = 5'b00001;
    reti = 1'b1; tick();
    boundary_tick();
    tick(); tick(); tick();
    tests_run++;
    if (irq_ack !== 5'b00001 || push_pcl !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_pre_reset: got ack=%b pcl=%b expected 00001/1", irq_ack, push_pcl);
    end
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    tests_run++;
    if (irq_ack !== 5'b0 || vector !== 16'h0000 || dispatch !== 1'b0 || ime !== 1'b0 || dbg_state !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL mid_reset: got ack=%b vec=%h disp=%b ime=%b state=%0d expected all 0", irq_ack, vector, dispatch, ime, dbg_state);
    end
    nffff_rd = 1'b0;
    #1;
    tests_run++;
    if (d !== 8'h00) begin
      tests_failed++;
      $display("FAIL mid_reset_ie: got %h expected 00", d);
    end
    nffff_rd = 1'b1;
    reset = 1'b0;
    irq_trig = 5'b00000;
    tick();
  endtask

  task automatic test_random();
    logic do_read;
    write_ie(8'h1F);
    for (int c = 0; c < 2000; c++) begin
      irq_trig = irq_trig | (($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'b0);
      instr_boundary = ($urandom_range(0, 2) == 0);
      ei   = ($urandom_range(0, 15) == 0);
      di   = ($urandom_range(0, 31) == 0);
      reti = ($urandom_range(0, 15) == 0);
      do_read = 1'b0;
      if ($urandom_range(0, 15) == 0) begin
        tb_d = 8'($urandom_range(0, 255)); tb_d_oe = 1'b1; nffff_wr = 1'b0;
      end else if ($urandom_range(0, 7) == 0) begin
        do_read = 1'b1; nffff_rd = 1'b0;
      end
      tick();
      instr_boundary = 1'b0;
      tests_run++;
      if (act_outs !== exp_outs()) begin
        tests_failed++;
        $display("FAIL random_c%0d: got %h expected %h", c, act_outs, exp_outs());
      end
      if (do_read) begin
        tests_run++;
        if (d !== m_ie) begin
          tests_failed++;
          $display("FAIL random_read_c%0d: got %h expected %h", c, d, m_ie);
        end
        nffff_rd = 1'b1;
      end
      irq_trig = irq_trig & ~m_ack;
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    tests_run = 0; tests_failed = 0;
    tb_d = 8'h00; tb_d_oe = 1'b0;
    nffff_wr = 1'b1; nffff_rd = 1'b1;
    irq_trig = 5'b0; instr_boundary = 1'b0;
    ei = 1'b0; di = 1'b0; reti = 1'b0;
    model_reset();
    test_reset();
    test_basic_dispatch();
    test_priority();
    test_late_mask();
    test_ei_delay();
    test_wake();
    test_reset_mid_dispatch();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
